vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
Top-level sequencer for the vending machine. It accepts coin events, accumulates credit, and drives a dispense handshake once credit reaches PRICE. It then pays out change or refunds one unit per handshake. It sits above the coin-detect FSM and arbitrates between the two output mechanisms (dispenser, change hopper), which never run concurrently. All amounts are in credit units: 1 unit = 5 cents.

Parameters:
PRICE, 3, item price in units.
MAX_CREDIT, 10, maximum credit the block will hold; must be >= PRICE+4.
CREDIT_W, 4, width of the credit register; must hold MAX_CREDIT.
TIMEOUT, 255, idle cycles in COLLECT before an automatic refund; must be >= 1.
TMR_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
coin_valid  in  1  one-cycle coin event.
coin_val  in  2  coin code: 01=nickel(1), 10=dime(2), 11=quarter(5), 00=invalid.
cancel  in  1  refund request (level, sampled each edge).
disp_req  out  1  dispense request to the dispenser.
disp_ack  in  1  dispenser acknowledge.
chg_req  out  1  request for one change unit from the hopper.
chg_ack  in  1  hopper acknowledge, one unit paid per cycle with req&ack.
credit  out  CREDIT_W  current credit.
state  out  2  current FSM state, for debug.
busy  out  1  high in DISPENSE or CHANGE.
coin_reject  out  1  one-cycle pulse: coin not accepted.
vend_done  out  1  one-cycle pulse: dispense acknowledged.

Behaviour:
- reset low (async):
  - state=IDLE, credit=0.
  - disp_req, chg_req, coin_reject and vend_done all 0; timer=0.
  - Reset mid-handshake drops req immediately; no refund is owed.
- All outputs are registered.
- States: IDLE=00, COLLECT=01, DISPENSE=10, CHANGE=11.
- IDLE/COLLECT, coin_valid=1 with valid code v:
  - If credit+v > MAX_CREDIT: coin_reject=1 next cycle, credit unchanged.
  - Else credit<=credit+v and timer<=0.
  - Next state is DISPENSE if credit+v >= PRICE, else COLLECT.
  - disp_req is high the cycle after the accepting edge.
- coin_val=00 with coin_valid, or any coin in DISPENSE/CHANGE: coin_reject pulse, credit unchanged.
- cancel in COLLECT: go to CHANGE; full credit becomes the refund.
  - cancel has priority over a same-cycle coin; that coin is rejected.
  - cancel in IDLE, DISPENSE or CHANGE is ignored.
- COLLECT timer:
  - Increments each cycle without a coin.
  - When timer==TIMEOUT-1 and no coin/cancel that cycle: go to CHANGE (auto-refund).
- DISPENSE:
  - disp_req held high until disp_ack is sampled high.
  - On that edge: disp_req<=0, credit<=credit-PRICE, vend_done=1 for one cycle.
  - Next state is CHANGE if the remainder > 0, else IDLE.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - chg_req=1 while credit>0.
  - Each edge with chg_req&chg_ack: credit<=credit-1.
  - On the edge credit reaches 0: chg_req<=0, state<=IDLE.
  - chg_ack with chg_req=0 is ignored; credit never underflows.
- IDLE is equivalent to credit==0; COLLECT always has 0 < credit < PRICE.
- busy = (state==DISPENSE)|(state==CHANGE).
- disp_req and chg_req are never both high.

Decomposition:
- vend_pkg holds:
  - state encodings (ST_IDLE, ST_COLLECT, ST_DISPENSE, ST_CHANGE);
  - coin codes (COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER);
  - a coin-value decode function returning 0/1/2/5.
- One sub-module: vend_timeout_timer.
  - Inputs: clock, reset, clear, enable.
  - Output: expire pulse at TIMEOUT.
  - Parameterised by TIMEOUT/TMR_W.
- The FSM, credit arithmetic and handshakes stay in vend_sequencer.

Test Plan:
1. Three nickels in consecutive cycles -> credit 1,2,3; disp_req high after the third edge; disp_ack 1 cycle -> vend_done pulse, credit 0, state IDLE, chg_req never asserted.
2. One quarter -> DISPENSE, ack -> credit 2, CHANGE; chg_ack held high 2 cycles -> credit 1 then 0, chg_req drops, state IDLE.
3. Dime, then cancel and nickel in the same cycle -> coin_reject pulse, state CHANGE with credit 2; two ack handshakes refund to 0; cancel in IDLE has no effect.
4. Nickel then nothing for TIMEOUT cycles (TIMEOUT=8 in bench) -> CHANGE after cycle 8, one unit refunded; a coin at cycle 7 restarts the timer instead.
5. Quarter, then dime during DISPENSE, then coin_val=00 in IDLE -> coin_reject pulse each time, credit unchanged, disp_req still high until ack.
6. Reset low mid-CHANGE with credit 3 and chg_req high -> chg_req, credit and state go to 0/IDLE before the next clock edge; normal operation resumes after reset high.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending sequencer.
//   - FSM state encodings (also exported on the debug 'state' port)
//   - coin codes as presented on coin_val
//   - coin_value(): coin code -> credit units (1 unit = 5 cents)
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COLLECT  = 2'b01,
        ST_DISPENSE = 2'b10,
        ST_CHANGE   = 2'b11
    } vend_state_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    // Returns 0 for an invalid code so callers can treat "value==0" as reject.
    function automatic logic [2:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_NICKEL:  coin_value = 3'd1;
            COIN_DIME:    coin_value = 3'd2;
            COIN_QUARTER: coin_value = 3'd5;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// vend_timeout_timer: idle-cycle counter for the COLLECT state.
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   clear  : restart the count at 0 (dominates enable)
//   enable : count this cycle
//   expire : high in the cycle the count sits at TIMEOUT-1 while enabled and
//            not cleared, i.e. the edge that ends the TIMEOUT-th idle cycle
module vend_timeout_timer #(
    parameter int TIMEOUT = 255,
    parameter int TMR_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt;

    assign expire = enable & ~clear & (cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= expire ? '0 : cnt + TMR_W'(1);
    end

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin collection, dispense handshake and change/refund payout.
//   clock, reset         : rising-edge clock, async active-low reset
//   coin_valid, coin_val : one-cycle coin event and its code
//   cancel               : refund request, honoured only in COLLECT
//   disp_req / disp_ack  : dispenser handshake
//   chg_req / chg_ack    : hopper handshake, one unit per req&ack cycle
//   credit, state, busy  : status (registered)
//   coin_reject          : one-cycle pulse, coin not accepted
//   vend_done            : one-cycle pulse, dispense acknowledged
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 10,
    parameter int CREDIT_W   = 4,
    parameter int TIMEOUT    = 255,
    parameter int TMR_W      = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic                cancel,
    output logic                disp_req,
    input  logic                disp_ack,
    output logic                chg_req,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          state,
    output logic                busy,
    output logic                coin_reject,
    output logic                vend_done
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   PRICE_S = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_S   = (CREDIT_W+1)'(MAX_CREDIT);

    vend_state_t         st, st_n;
    logic [CREDIT_W-1:0] credit_n;
    logic                coin_reject_n, vend_done_n;
    logic [2:0]          val;
    logic [CREDIT_W:0]   sum;
    logic                cancel_hit, coin_ok, chg_pay;
    logic                tmr_expire;

    assign val        = coin_value(coin_val);
    // One spare bit so an overflowing coin is detected rather than wrapping.
    assign sum        = {1'b0, credit} + (CREDIT_W+1)'(val);
    assign cancel_hit = (st == ST_COLLECT) & cancel;
    // A coin is taken only while collecting, never alongside an honoured cancel.
    assign coin_ok    = coin_valid & (val != 3'd0)
                      & ((st == ST_IDLE) | (st == ST_COLLECT))
                      & ~cancel_hit & (sum <= MAX_S);
    assign chg_pay    = chg_req & chg_ack;

    vend_timeout_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_tmr (
        .clock  (clock),
        .reset  (reset),
        .clear  ((st != ST_COLLECT) | coin_ok),
        .enable (st == ST_COLLECT),
        .expire (tmr_expire)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            st <= ST_IDLE;
        else
            st <= st_n;
    end

    // Next-state logic
    always_comb begin
        st_n = st;
        case (st)
            ST_IDLE:
                if (coin_ok)
                    st_n = (sum >= PRICE_S) ? ST_DISPENSE : ST_COLLECT;
            ST_COLLECT:
                if (cancel_hit)
                    st_n = ST_CHANGE;
                else if (coin_ok)
                    st_n = (sum >= PRICE_S) ? ST_DISPENSE : ST_COLLECT;
                else if (tmr_expire)
                    st_n = ST_CHANGE;
            ST_DISPENSE:
                if (disp_ack)
                    st_n = (credit > PRICE_C) ? ST_CHANGE : ST_IDLE;
            ST_CHANGE:
                // Leave on the edge that pays the last unit; the credit==0 arm
                // only guards against ever parking here with nothing owed.
                if ((credit == '0) | (chg_pay & (credit == CREDIT_W'(1))))
                    st_n = ST_IDLE;
            default:
                st_n = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        credit_n      = credit;
        coin_reject_n = coin_valid & ~coin_ok;
        vend_done_n   = 1'b0;
        case (st)
            ST_IDLE, ST_COLLECT:
                if (coin_ok)
                    credit_n = sum[CREDIT_W-1:0];
            ST_DISPENSE:
                if (disp_ack) begin
                    credit_n    = credit - PRICE_C;
                    vend_done_n = 1'b1;
                end
            ST_CHANGE:
                if (chg_pay & (credit != '0))
                    credit_n = credit - CREDIT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            credit      <= '0;
            disp_req    <= 1'b0;
            chg_req     <= 1'b0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
            vend_done   <= 1'b0;
        end else begin
            credit      <= credit_n;
            disp_req    <= (st_n == ST_DISPENSE);
            chg_req     <= (st_n == ST_CHANGE) & (credit_n != '0);
            busy        <= (st_n == ST_DISPENSE) | (st_n == ST_CHANGE);
            coin_reject <= coin_reject_n;
            vend_done   <= vend_done_n;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: each stimulus cycle pushes the expected
// post-edge outputs from a transaction-level model; a monitor pops and compares
// them half a cycle after the edge. Reset behaviour is checked directly.
module tb_vend_sequencer;

    localparam int PRICE      = 3;
    localparam int MAX_CREDIT = 10;
    localparam int CREDIT_W   = 4;
    localparam int TIMEOUT    = 8;
    localparam int TMR_W      = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                coin_valid = 1'b0;
    logic [1:0]          coin_val = 2'b00;
    logic                cancel = 1'b0;
    logic                disp_ack = 1'b0;
    logic                chg_ack = 1'b0;
    logic                disp_req, chg_req, busy, coin_reject, vend_done;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          state;

    vend_sequencer #(
        .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W),
        .TIMEOUT(TIMEOUT), .TMR_W(TMR_W)
    ) dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel), .disp_req(disp_req), .disp_ack(disp_ack),
        .chg_req(chg_req), .chg_ack(chg_ack), .credit(credit), .state(state),
        .busy(busy), .coin_reject(coin_reject), .vend_done(vend_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int st; int cr; int dr; int cq; int bz; int rj; int vd;
    } snap_t;

    snap_t exp_q[$];
    snap_t mon_e;
    int    n_chk = 0;
    int    n_fail = 0;

    // Model: mode 0 idle, 1 collecting, 2 vending, 3 paying out.
    int m_mode = 0, m_credit = 0, m_idle = 0;
    int cval[4] = '{0, 1, 2, 5};

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
        end
    endtask

    task automatic step(input bit cv, input bit [1:0] code, input bit cn,
                        input bit da, input bit ca);
        snap_t e;
        int    v;
        bit    acc;
        coin_valid = cv; coin_val = code; cancel = cn; disp_ack = da; chg_ack = ca;
        e.rj = 0; e.vd = 0; acc = 0;
        v = cval[code];
        if (m_mode <= 1) begin
            if (m_mode == 1 && cn) begin
                e.rj = int'(cv);
                m_mode = 3;
            end else begin
                if (cv) begin
                    if (v == 0 || m_credit + v > MAX_CREDIT) e.rj = 1;
                    else begin
                        m_credit += v;
                        acc = 1;
                        m_idle = 0;
                        m_mode = (m_credit >= PRICE) ? 2 : 1;
                    end
                end
                if (!acc && m_mode == 1) begin
                    if (m_idle == TIMEOUT - 1) m_mode = 3;
                    else m_idle++;
                end
            end
        end else if (m_mode == 2) begin
            e.rj = int'(cv);
            if (da) begin
                m_credit -= PRICE;
                e.vd = 1;
                m_mode = (m_credit > 0) ? 3 : 0;
            end
        end else begin
            e.rj = int'(cv);
            if (ca && m_credit > 0) m_credit--;
            if (m_credit == 0) m_mode = 0;
        end
        if (m_mode != 1) m_idle = 0;
        e.st = m_mode;
        e.cr = m_credit;
        e.dr = (m_mode == 2) ? 1 : 0;
        e.cq = (m_mode == 3 && m_credit > 0) ? 1 : 0;
        e.bz = (m_mode >= 2) ? 1 : 0;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},  int'(state), 0);
        chk({tag, "_credit"}, int'(credit), 0);
        chk({tag, "_dreq"},   int'(disp_req), 0);
        chk({tag, "_creq"},   int'(chg_req), 0);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_rej"},    int'(coin_reject), 0);
        chk({tag, "_done"},   int'(vend_done), 0);
    endtask

    // Monitor: an entry present at an edge describes that edge's result.
    initial begin
        forever begin
            @(posedge clock);
            if (exp_q.size() > 0) begin
                @(negedge clock);
                mon_e = exp_q.pop_front();
                chk("state",       int'(state),       mon_e.st);
                chk("credit",      int'(credit),      mon_e.cr);
                chk("disp_req",    int'(disp_req),    mon_e.dr);
                chk("chg_req",     int'(chg_req),     mon_e.cq);
                chk("busy",        int'(busy),        mon_e.bz);
                chk("coin_reject", int'(coin_reject), mon_e.rj);
                chk("vend_done",   int'(vend_done),   mon_e.vd);
                chk("req_excl",    int'(disp_req & chg_req), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // 1: three nickels, vend, no change
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0);
        idle(2);
        step(0, 2'b00, 0, 1, 0);
        idle(1);

        // 2: quarter, vend, two units of change with ack held
        step(1, 2'b11, 0, 0, 0);
        step(0, 2'b00, 0, 1, 0);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 1);
        idle(1);

        // 3: dime, cancel beats a same-cycle nickel, refund, cancel in IDLE
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b01, 1, 0, 0);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 1, 0, 0);
        idle(1);

        // 4: timeout refund, then a coin just before timeout restarts the timer
        step(1, 2'b01, 0, 0, 0);
        idle(TIMEOUT);
        step(0, 2'b00, 0, 0, 1);
        step(1, 2'b01, 0, 0, 0);
        idle(TIMEOUT - 2);
        step(1, 2'b01, 0, 0, 0);
        idle(TIMEOUT);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 1);

        // 5: coin during DISPENSE and invalid code in IDLE are rejected
        step(1, 2'b11, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        idle(1);
        step(0, 2'b00, 0, 1, 0);
        step(0, 2'b00, 0, 0, 1);
        step(0, 2'b00, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0);
        idle(1);

        // 6: async reset in the middle of a 3-unit payout
        step(1, 2'b01, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0);
        step(0, 2'b00, 0, 1, 0);
        idle(1);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        m_mode = 0; m_credit = 0; m_idle = 0;
        coin_valid = 0; coin_val = 2'b00; cancel = 0; disp_ack = 0; chg_ack = 0;
        @(posedge clock);
        #1;
        check_reset_outputs("held_rst");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(1, 2'b10, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0);
        step(0, 2'b00, 0, 1, 0);
        step(0, 2'b00, 0, 0, 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) == 0), 2'($urandom_range(3)),
                 ($urandom_range(15) == 0), ($urandom_range(2) == 0),
                 ($urandom_range(1) == 0));
        end

        @(negedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
